point_frame_scheduler: RTL and testbench
========================================

# point_frame_scheduler

Controller in front of the LiDAR decoder's point-cloud assembler. It arbitrates between several point sources with a round-robin scheme, and locks the grant to one source for a whole frame. It packs the granted source's 128-bit points four at a time into 512-bit beats and emits them on a valid/ready output, flushing a zero-padded partial beat at end of frame. It replaces free-running shift-in buffering with explicit sequencing and backpressure.

## Interface
- NUM_SRC, 2, number of point sources (2..8)
- POINT_W, 128, bits per point
- POINTS_PER_BEAT, 4, points packed per output beat
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- src_valid  input  NUM_SRC  per-source point valid
- src_point  input  NUM_SRC*POINT_W  per-source point; source i at [POINT_W*i +: POINT_W]
- src_last  input  NUM_SRC  point is the last of its frame; qualified by src_valid
- src_ready  output  NUM_SRC  per-source accept; one-hot or zero
- beat_valid  output  1  output beat valid
- beat_data  output  512  packed points
- beat_count  output  3  number of valid points in beat (1..4)
- beat_last  output  1  beat closes a frame
- beat_src  output  3  index of the source that produced the beat
- beat_ready  input  1  downstream accept
- frame_done  output  1  one-cycle pulse on final beat handshake (macro-gated)
- frame_points  output  16  point count of current/last frame (macro-gated)

## Operation
- FSM states: IDLE, FILL, EMIT.
- IDLE: the arbiter picks the first index at or after rr_ptr, with wrap, whose src_valid=1. It registers the grant and goes to FILL. No point is accepted in this cycle.
- FILL: src_ready[grant]=1, all others 0. A point is accepted when valid&ready. The k-th accepted point of a beat goes to beat_data[128k+127:128k], so the first point sits at the LSBs.
- FILL goes to EMIT on the 4th accept, or on any accept with src_last=1.
- Unused slots of a partial beat are zero. beat_count equals the number of slots filled. beat_last equals src_last of the final accepted point.
- EMIT: beat_valid=1. beat_data, beat_count, beat_last and beat_src stay stable until beat_ready=1.
  - On handshake with beat_last=0: go to FILL with slot index 0 and the same grant.
  - On handshake with beat_last=1: go to IDLE and set rr_ptr = (grant+1) mod NUM_SRC.
- src_ready is all zero in IDLE and EMIT. A source holding src_valid is simply stalled.
- Empty frames are impossible: src_last is meaningful only alongside a point.
- Reset: state IDLE, rr_ptr 0, slot 0, and all outputs 0. Any partially packed beat is discarded, including on reset mid-frame.

## Timing
- beat_valid rises in the cycle after the accept that completes the beat.
- Output registers hold from EMIT entry until handshake.
- Peak throughput is 4 points per 5 cycles (4 FILL cycles + 1 EMIT cycle), with beat_ready tied high.
- Frame-to-frame gap: 1 IDLE cycle after the last handshake before the next grant.
- beat_ready asserted outside EMIT is ignored.
- The arbiter samples only in IDLE. src_valid changes during FILL/EMIT on non-granted sources have no effect.

## Configuration
- PCA_FRAME_STATS_EN defined:
  - frame_points is set to 1 on the first accept of a frame and increments on each later accept, saturating at 16'hFFFF.
  - After the frame ends it holds its value until the next frame's first accept.
  - frame_done pulses high for exactly one cycle, the cycle the beat_last handshake occurs.
- Not defined: frame_points and frame_done are tied to 0 and the counter logic is absent.

## Structure
- Shared package pca_pkg:
  - POINT_W, POINTS_PER_BEAT and BEAT_W (512)
  - state enum typedef (IDLE, FILL, EMIT)
  - point_t (logic [127:0])
- One sub-module, pca_rr_arbiter, which is combinational. It takes the request vector and rr_ptr and returns the grant index plus a found flag. It is reusable elsewhere in the decoder.

## Test plan
- Source 0 sends 4 points A..D with D last, beat_ready=1. Required: one beat with beat_data={D,C,B,A}, beat_count=4, beat_last=1, beat_src=0, beat_valid in the cycle after D's accept.
- Source 1 sends 6 points, last on the 6th. Required: two beats, counts 4 then 2. The second beat has bits [511:256]=0 and beat_last=1. frame_points=6 and a single frame_done pulse (stats enabled).
- Both sources valid continuously from reset, each sending 2-point frames. Required: grants alternate 0,1,0,1, and src_ready is never asserted for two sources at once.
- beat_ready held low for 10 cycles in EMIT. Required: beat outputs stable and src_ready=0 throughout, with no point lost or duplicated after release.
- reset asserted mid-frame after 3 accepts. Required: all outputs 0 next cycle. The next frame from source 0 starts at slot 0 with rr_ptr=0.
- Build without PCA_FRAME_STATS_EN. Required: frame_points=0 and frame_done=0 across all scenarios, and beats identical to the enabled build.

Source files
------------

// File: rtl/pca_pkg.sv
// Shared types and constants for the point-cloud frame scheduler and its arbiter.
package pca_pkg;

  localparam int POINT_W         = 128;
  localparam int POINTS_PER_BEAT = 4;
  localparam int BEAT_W          = POINT_W * POINTS_PER_BEAT;
  localparam int IDX_W           = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT
  } state_t;

  typedef logic [POINT_W-1:0] point_t;

  // Source index following idx, wrapping at n.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/pca_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, with wrap.
module pca_rr_arbiter
  import pca_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               found_o
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (req_i[i] && (i == ((int'(ptr_i) + off) % NUM_SRC))) begin
          grant_o = IDX_W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/point_frame_scheduler.sv
// Frame-locked round-robin scheduler packing 128-bit points into 512-bit beats.
// Optional frame statistics (frame_points, frame_done) enabled by PCA_FRAME_STATS_EN.
module point_frame_scheduler #(
  parameter int NUM_SRC         = 2,
  parameter int POINT_W         = 128,
  parameter int POINTS_PER_BEAT = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_SRC-1:0]                   src_valid,
  input  logic [NUM_SRC*POINT_W-1:0]           src_point,
  input  logic [NUM_SRC-1:0]                   src_last,
  output logic [NUM_SRC-1:0]                   src_ready,
  output logic                                 beat_valid,
  output logic [POINT_W*POINTS_PER_BEAT-1:0]   beat_data,
  output logic [2:0]                           beat_count,
  output logic                                 beat_last,
  output logic [2:0]                           beat_src,
  input  logic                                 beat_ready,
  output logic                                 frame_done,
  output logic [15:0]                          frame_points
);
  import pca_pkg::*;

  localparam int BW = POINT_W * POINTS_PER_BEAT;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [2:0]           slot_q, slot_d;
  logic [BW-1:0]        data_q, data_d;
  logic                 last_q, last_d;

  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_found;
  logic [NUM_SRC-1:0]   grant_oh;
  logic [POINTS_PER_BEAT-1:0] slot_wr;
  logic [POINT_W-1:0]   sel_point;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 accept;
  logic                 beat_hs;

  pca_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req_i   (src_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_idx),
    .found_o (arb_found)
  );

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_oh
      assign grant_oh[gi] = (grant_q == IDX_W'(gi));
    end
    for (genvar gi = 0; gi < POINTS_PER_BEAT; gi++) begin : g_slot
      assign slot_wr[gi] = accept && (slot_q == 3'(gi));
    end
  endgenerate

  always_comb begin
    sel_point = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_oh[i]) begin
        sel_point = sel_point | src_point[i*POINT_W +: POINT_W];
      end
    end
  end

  assign sel_valid = |(src_valid & grant_oh);
  assign sel_last  = |(src_last & grant_oh);
  assign accept    = (state_q == FILL) && sel_valid;
  assign beat_hs   = (state_q == EMIT) && beat_ready;
  assign src_ready = (state_q == FILL) ? grant_oh : '0;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    slot_d   = slot_q;
    data_d   = data_q;
    last_d   = last_q;
    for (int k = 0; k < POINTS_PER_BEAT; k++) begin
      if (slot_wr[k]) begin
        data_d[k*POINT_W +: POINT_W] = sel_point;
      end
    end
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          slot_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          slot_d = slot_q + 3'd1;
          last_d = sel_last;
          if ((slot_q == 3'(POINTS_PER_BEAT - 1)) || sel_last) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        // The buffer is cleared here so a following partial beat is zero-padded.
        if (beat_ready) begin
          data_d = '0;
          slot_d = '0;
          last_d = 1'b0;
          if (last_q) begin
            rr_ptr_d = next_idx(grant_q, NUM_SRC);
            state_d  = IDLE;
          end else begin
            state_d  = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      slot_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      slot_q   <= slot_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign beat_valid = (state_q == EMIT);
  assign beat_data  = data_q;
  assign beat_count = slot_q;
  assign beat_last  = last_q;
  assign beat_src   = grant_q;

`ifdef PCA_FRAME_STATS_EN
  logic [15:0] frame_points_q, frame_points_d;
  logic        first_q, first_d;

  always_comb begin
    frame_points_d = frame_points_q;
    first_d        = first_q;
    if (accept) begin
      first_d = 1'b0;
      if (first_q) begin
        frame_points_d = 16'd1;
      end else if (frame_points_q != 16'hFFFF) begin
        frame_points_d = frame_points_q + 16'd1;
      end
    end
    if (beat_hs && last_q) begin
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_points_q <= '0;
      first_q        <= 1'b1;
    end else begin
      frame_points_q <= frame_points_d;
      first_q        <= first_d;
    end
  end

  assign frame_points = frame_points_q;
  assign frame_done   = beat_hs && last_q;
`else
  assign frame_points = '0;
  assign frame_done   = 1'b0;
`endif

endmodule

// File: tb/tb_point_frame_scheduler.sv
// Directed bench for point_frame_scheduler; honours PCA_FRAME_STATS_EN when defined.
module tb_point_frame_scheduler;

`ifdef PCA_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   src_valid;
  logic [255:0] src_point;
  logic [1:0]   src_last;
  logic [1:0]   src_ready;
  logic         beat_valid;
  logic [511:0] beat_data;
  logic [2:0]   beat_count;
  logic         beat_last;
  logic [2:0]   beat_src;
  logic         beat_ready;
  logic         frame_done;
  logic [15:0]  frame_points;

  point_frame_scheduler #(
    .NUM_SRC (2), .POINT_W (128), .POINTS_PER_BEAT (4)
  ) dut (
    .clk (clk), .reset (reset),
    .src_valid (src_valid), .src_point (src_point), .src_last (src_last),
    .src_ready (src_ready),
    .beat_valid (beat_valid), .beat_data (beat_data), .beat_count (beat_count),
    .beat_last (beat_last), .beat_src (beat_src), .beat_ready (beat_ready),
    .frame_done (frame_done), .frame_points (frame_points)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [2:0]   cnt;
    logic         last;
    logic [2:0]   src;
    int           stp;
  } beat_t;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;
  int last_acc_step = 0;
  int acc_total = 0;
  int fd_count = 0;
  logic [128:0] q0[$];
  logic [128:0] q1[$];
  beat_t capq[$];
  logic br = 1'b1;

  function automatic logic [127:0] mkpt(input int tag);
    return {4{32'(tag)}};
  endfunction

  task automatic push(input int s, input int tag, input logic last);
    if (s == 0) q0.push_back({last, mkpt(tag)});
    else        q1.push_back({last, mkpt(tag)});
  endtask

  task automatic drive();
    src_valid = 2'b00; src_last = 2'b00; src_point = '0;
    if (q0.size() > 0) begin
      src_valid[0] = 1'b1; src_last[0] = q0[0][128]; src_point[127:0] = q0[0][127:0];
    end
    if (q1.size() > 0) begin
      src_valid[1] = 1'b1; src_last[1] = q1[0][128]; src_point[255:128] = q1[0][127:0];
    end
    beat_ready = br;
  endtask

  // One clock: sample at negedge, then update inputs just after posedge.
  task automatic step();
    logic [1:0] acc;
    logic       fd_exp;
    @(negedge clk);
    vectors++;
    if ($countones(src_ready) > 1) begin
      miscompares++;
      $display("FAIL onehot: src_ready=%b required at most one bit", src_ready);
    end
    fd_exp = STATS && beat_valid && beat_ready && beat_last;
    vectors++;
    if (frame_done !== fd_exp) begin
      miscompares++;
      $display("FAIL frame_done step %0d: got %b required %b", step_no, frame_done, fd_exp);
    end
    if (frame_done === 1'b1) fd_count++;
    acc = src_valid & src_ready;
    if (beat_valid && beat_ready) begin
      capq.push_back('{beat_data, beat_count, beat_last, beat_src, step_no});
      $display("beat: src=%0d count=%0d last=%b data[127:0]=%h", beat_src, beat_count, beat_last, beat_data[127:0]);
    end
    @(posedge clk);
    #1;
    if (acc[0] && q0.size() > 0) begin
      if (q0[0][128]) last_acc_step = step_no;
      q0.delete(0);
      acc_total++;
    end
    if (acc[1] && q1.size() > 0) begin
      if (q1[0][128]) last_acc_step = step_no;
      q1.delete(0);
      acc_total++;
    end
    drive();
    step_no++;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k = 0;
    while (capq.size() < n && k < budget) begin
      step();
      k++;
    end
    vectors++;
    if (capq.size() < n) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d beats required %0d", name, capq.size(), n);
    end
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); capq.delete();
    br = 1'b1;
    reset = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle_zero(input string name);
    vectors++;
    if (beat_valid !== 1'b0 || src_ready !== 2'b00 || beat_data !== '0 || beat_count !== 3'd0 ||
        beat_last !== 1'b0 || beat_src !== 3'd0 || frame_points !== 16'd0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: valid=%b ready=%b count=%0d last=%b src=%0d fp=%0d fd=%b required all 0",
               name, beat_valid, src_ready, beat_count, beat_last, beat_src, frame_points, frame_done);
    end
  endtask

  task automatic check_fp(input string name, input logic [15:0] exp_on);
    logic [15:0] exp;
    exp = STATS ? exp_on : 16'd0;
    vectors++;
    if (frame_points !== exp) begin
      miscompares++;
      $display("FAIL %s: frame_points=%0d required %0d", name, frame_points, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_idle_zero("reset_state");
  endtask

  task automatic test_full_beat();
    logic [511:0] exp;
    capq.delete();
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 0); push(0, 4, 1);
    drive();
    run_until(1, 30, "full_beat");
    exp = {mkpt(4), mkpt(3), mkpt(2), mkpt(1)};
    if (capq.size() >= 1) begin
      vectors++;
      if (capq[0].data !== exp || capq[0].cnt !== 3'd4 || capq[0].last !== 1'b1 || capq[0].src !== 3'd0) begin
        miscompares++;
        $display("FAIL full_beat: cnt=%0d last=%b src=%0d data=%h required cnt=4 last=1 src=0 data=%h",
                 capq[0].cnt, capq[0].last, capq[0].src, capq[0].data, exp);
      end
      vectors++;
      if (capq[0].stp !== last_acc_step + 1) begin
        miscompares++;
        $display("FAIL full_beat_latency: beat at step %0d required %0d", capq[0].stp, last_acc_step + 1);
      end
    end
    check_fp("full_beat_points", 16'd4);
  endtask

  task automatic test_partial_beat();
    logic [511:0] exp;
    capq.delete();
    fd_count = 0;
    for (int i = 1; i <= 6; i++) push(1, 100 + i, (i == 6));
    drive();
    run_until(2, 40, "partial");
    repeat (2) step();
    if (capq.size() >= 2) begin
      exp = {mkpt(104), mkpt(103), mkpt(102), mkpt(101)};
      vectors++;
      if (capq[0].data !== exp || capq[0].cnt !== 3'd4 || capq[0].last !== 1'b0 || capq[0].src !== 3'd1) begin
        miscompares++;
        $display("FAIL partial_first: cnt=%0d last=%b src=%0d required cnt=4 last=0 src=1",
                 capq[0].cnt, capq[0].last, capq[0].src);
      end
      exp = {256'd0, mkpt(106), mkpt(105)};
      vectors++;
      if (capq[1].data !== exp || capq[1].cnt !== 3'd2 || capq[1].last !== 1'b1) begin
        miscompares++;
        $display("FAIL partial_second: cnt=%0d last=%b data=%h required cnt=2 last=1 data=%h",
                 capq[1].cnt, capq[1].last, capq[1].data, exp);
      end
    end
    check_fp("partial_points", 16'd6);
    vectors++;
    if (fd_count !== (STATS ? 1 : 0)) begin
      miscompares++;
      $display("FAIL partial_frame_done: pulses=%0d required %0d", fd_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_alternate();
    logic [2:0] exp_src [4];
    logic [511:0] exp_data [4];
    do_reset();
    push(0, 10, 0); push(0, 11, 1); push(0, 12, 0); push(0, 13, 1);
    push(1, 20, 0); push(1, 21, 1); push(1, 22, 0); push(1, 23, 1);
    drive();
    exp_src  = '{3'd0, 3'd1, 3'd0, 3'd1};
    exp_data[0] = {256'd0, mkpt(11), mkpt(10)};
    exp_data[1] = {256'd0, mkpt(21), mkpt(20)};
    exp_data[2] = {256'd0, mkpt(13), mkpt(12)};
    exp_data[3] = {256'd0, mkpt(23), mkpt(22)};
    run_until(4, 60, "alternate");
    for (int i = 0; i < 4 && i < capq.size(); i++) begin
      vectors++;
      if (capq[i].src !== exp_src[i] || capq[i].data !== exp_data[i] || capq[i].cnt !== 3'd2) begin
        miscompares++;
        $display("FAIL alternate_%0d: src=%0d cnt=%0d required src=%0d cnt=2", i, capq[i].src, capq[i].cnt, exp_src[i]);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [511:0] exp;
    int k;
    capq.delete();
    br = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 30 + i, (i == 4));
    drive();
    k = 0;
    while (!beat_valid && k < 20) begin
      step();
      k++;
    end
    exp = {mkpt(33), mkpt(32), mkpt(31), mkpt(30)};
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (beat_valid !== 1'b1 || src_ready !== 2'b00 || beat_data !== exp || beat_count !== 3'd4) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: valid=%b ready=%b count=%0d required valid=1 ready=0 count=4",
                 c, beat_valid, src_ready, beat_count);
      end
      step();
    end
    br = 1'b1;
    drive();
    run_until(2, 30, "stall_release");
    if (capq.size() >= 2) begin
      vectors++;
      if (capq[0].data !== exp || capq[0].last !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_first: last=%b data=%h required last=0 data=%h", capq[0].last, capq[0].data, exp);
      end
      exp = {384'd0, mkpt(34)};
      vectors++;
      if (capq[1].data !== exp || capq[1].cnt !== 3'd1 || capq[1].last !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_second: cnt=%0d last=%b data=%h required cnt=1 last=1 data=%h",
                 capq[1].cnt, capq[1].last, capq[1].data, exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [511:0] exp;
    int start;
    int k;
    capq.delete();
    for (int i = 0; i < 5; i++) push(0, 40 + i, (i == 4));
    drive();
    start = acc_total;
    k = 0;
    while ((acc_total - start) < 3 && k < 30) begin
      step();
      k++;
    end
    reset = 1'b1;
    q0.delete(); q1.delete();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_mid_frame");
    @(posedge clk);
    #1;
    push(0, 50, 1);
    push(1, 60, 1);
    drive();
    run_until(2, 30, "after_reset");
    if (capq.size() >= 2) begin
      exp = {384'd0, mkpt(50)};
      vectors++;
      if (capq[0].src !== 3'd0 || capq[0].data !== exp || capq[0].cnt !== 3'd1 || capq[0].last !== 1'b1) begin
        miscompares++;
        $display("FAIL after_reset_first: src=%0d cnt=%0d data=%h required src=0 cnt=1 data=%h",
                 capq[0].src, capq[0].cnt, capq[0].data, exp);
      end
      vectors++;
      if (capq[1].src !== 3'd1) begin
        miscompares++;
        $display("FAIL after_reset_second: src=%0d required 1", capq[1].src);
      end
    end
    repeat (2) step();
    check_fp("after_reset_points", 16'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive();
    test_reset();
    test_full_beat();
    test_partial_beat();
    test_alternate();
    test_back_to_back_stall();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
